divider_sequencer: RTL and testbench

- Programmable controller for the toggle-flop divider datapath. It accepts a divisor over a valid/ready handshake and starts and stops the divider cleanly.
- Produces a one-cycle `tick` every N clocks and a `div_out` that toggles on each tick, i.e. divide-by-2N with 50% duty.
- Divisor changes and stops take effect only at a period boundary, so `div_out` never glitches or shortens a half-period.
- Sits between system control logic and any sequential block that needs a slow enable or divided clock.

---
 rtl/divider_sequencer_pkg.sv | 13 +
 rtl/divider_sequencer_if.sv | 42 ++++
 rtl/divider_period_counter.sv | 27 ++
 rtl/divider_sequencer.sv | 108 ++++++++++
 tb/tb_divider_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/divider_sequencer_pkg.sv
// divider_sequencer_pkg: shared state encoding, default width and divisor clamp
package divider_sequencer_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // A divisor of zero has no meaningful period, so it is treated as one
    function automatic int unsigned clamp_div(input int unsigned div);
        return (div == 0) ? 1 : div;
    endfunction

endpackage

// File: rtl/divider_sequencer_if.sv
// divider_sequencer_if: configuration handshake, run control and divider outputs
// Burst ports exist only when DIVIDER_SEQUENCER_BURST_EN is defined
interface divider_sequencer_if import divider_sequencer_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_div;
    logic             start;
    logic             stop;
    logic             busy;
    logic             tick;
    logic             div_out;
    logic [WIDTH-1:0] cur_div;

`ifdef DIVIDER_SEQUENCER_BURST_EN
    logic [WIDTH-1:0] burst_len;
    logic             burst_done;

    modport master (
        output cfg_valid, cfg_div, start, stop, burst_len,
        input  cfg_ready, busy, tick, div_out, cur_div, burst_done
    );

    modport slave (
        input  cfg_valid, cfg_div, start, stop, burst_len,
        output cfg_ready, busy, tick, div_out, cur_div, burst_done
    );
`else
    modport master (
        output cfg_valid, cfg_div, start, stop,
        input  cfg_ready, busy, tick, div_out, cur_div
    );

    modport slave (
        input  cfg_valid, cfg_div, start, stop,
        output cfg_ready, busy, tick, div_out, cur_div
    );
`endif

endinterface

// File: rtl/divider_period_counter.sv
// divider_period_counter: WIDTH-bit period counter with sync clear, wrap at i_div-1 and tick
module divider_period_counter import divider_sequencer_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_div,
    output logic             o_tick
);

    logic [WIDTH-1:0] r_count;

    assign o_tick = i_en && (r_count == i_div - WIDTH'(1));

    // Count 0..i_div-1 while enabled, restarting at 0 after the tick cycle
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_en)
            r_count <= o_tick ? '0 : r_count + WIDTH'(1);
    end

endmodule

// File: rtl/divider_sequencer.sv
// divider_sequencer: start/stop and divisor control for a divide-by-2N toggle divider
// Optional burst mode (burst_len / burst_done) enabled by DIVIDER_SEQUENCER_BURST_EN
module divider_sequencer import divider_sequencer_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int RESET_DIV = 1
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    divider_sequencer_if.slave  bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_cur_div;
    logic [WIDTH-1:0] r_pend_div;
    logic             r_pend;
    logic             r_div_out;
    logic             r_stop_req;
    logic             w_tick;
    logic             w_xfer;
    logic             w_launch;
    logic             w_run_exit;
    logic [WIDTH-1:0] w_new_div;

    assign bus.cfg_ready = (r_state == IDLE) || (r_state == RUN && !r_pend);
    assign bus.busy      = r_state != IDLE;
    assign bus.tick      = w_tick;
    assign bus.div_out   = r_div_out;
    assign bus.cur_div   = r_cur_div;

    assign w_xfer    = bus.cfg_valid && bus.cfg_ready;
    assign w_new_div = WIDTH'(clamp_div(32'(bus.cfg_div)));

`ifdef DIVIDER_SEQUENCER_BURST_EN
    logic [WIDTH-1:0] r_burst_left;
    logic             r_burst_done;
    logic             r_burst_hold;
    logic             w_burst_end;

    // Leave RUN one period early so the final burst period is the drain period
    assign w_burst_end = r_state == RUN &&
                         (r_burst_left == WIDTH'(1) || (w_tick && r_burst_left == WIDTH'(2)));
    assign w_launch    = bus.start && !r_burst_hold;
    assign w_run_exit  = bus.stop || !bus.start || r_stop_req || w_burst_end;
    assign bus.burst_done = r_burst_done;
`else
    assign w_launch    = bus.start;
    assign w_run_exit  = bus.stop || !bus.start || r_stop_req;
`endif

    divider_period_counter #(.WIDTH(WIDTH)) u_counter (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (r_state == IDLE),
        .i_en      (r_state != IDLE),
        .i_div     (r_cur_div),
        .o_tick    (w_tick)
    );

    // FSM, divisor bookkeeping and divided-output flop; changes land only on period boundaries
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_cur_div  <= WIDTH'(RESET_DIV);
            r_pend_div <= '0;
            r_pend     <= 1'b0;
            r_div_out  <= 1'b0;
            r_stop_req <= 1'b0;
`ifdef DIVIDER_SEQUENCER_BURST_EN
            r_burst_left <= '0;
            r_burst_done <= 1'b0;
            r_burst_hold <= 1'b0;
`endif
        end else begin
            if (w_tick)
                r_div_out <= !r_div_out;
            if (w_xfer && r_state == IDLE)
                r_cur_div <= w_new_div;
            else if (w_tick && r_pend)
                r_cur_div <= r_pend_div;
            if (w_xfer && r_state != IDLE) begin
                r_pend     <= 1'b1;
                r_pend_div <= w_new_div;
            end else if (w_tick) begin
                r_pend     <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_state    <= RUN;
                        r_stop_req <= bus.stop;
                    end
                end
                RUN:     if (w_run_exit) r_state <= DRAIN;
                DRAIN:   if (w_tick) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
`ifdef DIVIDER_SEQUENCER_BURST_EN
            if (r_state == IDLE && w_launch)
                r_burst_left <= bus.burst_len;
            else if (w_tick && r_burst_left != '0)
                r_burst_left <= r_burst_left - WIDTH'(1);
            r_burst_done <= r_state == DRAIN && w_tick;
            r_burst_hold <= w_burst_end || (r_burst_hold && bus.start);
`endif
        end
    end

endmodule

// File: tb/tb_divider_sequencer.sv
// tb_divider_sequencer: directed checks of handshake, periods, drain, reset and burst mode
module tb_divider_sequencer;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    divider_sequencer_if #(.WIDTH(8)) bus_if ();

    divider_sequencer #(.WIDTH(8), .RESET_DIV(1)) dut (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .bus       (bus_if)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic t, input logic d, input logic b,
                              input logic r, input logic [7:0] c);
        check({tag, "/tick"},      bus_if.tick,      t);
        check({tag, "/div_out"},   bus_if.div_out,   d);
        check({tag, "/busy"},      bus_if.busy,      b);
        check({tag, "/cfg_ready"}, bus_if.cfg_ready, r);
        check({tag, "/cur_div"},   bus_if.cur_div,   c);
    endtask

    initial begin
        bus_if.cfg_valid = 1'b0;
        bus_if.cfg_div   = '0;
        bus_if.start     = 1'b0;
        bus_if.stop      = 1'b0;
`ifdef DIVIDER_SEQUENCER_BURST_EN
        bus_if.burst_len = '0;
`endif
        #2 reset_n = 1'b0;
        #1;
        expect_all("reset", 0, 0, 0, 1, 1);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // N=3: ticks on RUN cycles 3,6,9, div_out 1,0,1 after them, then drain on start=0
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_div   = 8'd3;
        cyc();
        bus_if.cfg_valid = 1'b0;
        expect_all("t1_cfg", 0, 0, 0, 1, 3);
        bus_if.start = 1'b1;
        cyc();
        for (int i = 1; i <= 9; i++) begin
            expect_all($sformatf("t1_run%0d", i), (i % 3 == 0), 1'(((i - 1) / 3) % 2), 1, 1, 3);
            cyc();
        end
        expect_all("t1_c10", 0, 1, 1, 1, 3);
        bus_if.start = 1'b0;
        cyc();
        expect_all("t1_dr1", 0, 1, 1, 0, 3);
        cyc();
        expect_all("t1_dr2", 1, 1, 1, 0, 3);
        cyc();
        expect_all("t1_idle", 0, 0, 0, 1, 3);

        // cfg_div=0 clamps to 1: tick every cycle, exit after one drain cycle
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_div   = 8'd0;
        bus_if.start     = 1'b1;
        cyc();
        bus_if.cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_all($sformatf("t2_run%0d", i), 1, 1'(i % 2), 1, 1, 1);
            if (i == 3) bus_if.start = 1'b0;
            cyc();
        end
        expect_all("t2_drain", 1, 0, 1, 0, 1);
        cyc();
        expect_all("t2_idle", 0, 1, 0, 1, 1);

        // N=4 with divisor 2 accepted at counter=1: pending until the tick, then 2-cycle periods
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_div   = 8'd4;
        bus_if.start     = 1'b1;
        cyc();
        bus_if.cfg_valid = 1'b0;
        expect_all("t3_c0", 0, 1, 1, 1, 4);
        cyc();
        expect_all("t3_c1", 0, 1, 1, 1, 4);
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_div   = 8'd2;
        cyc();
        bus_if.cfg_valid = 1'b0;
        expect_all("t3_c2", 0, 1, 1, 0, 4);
        cyc();
        expect_all("t3_c3", 1, 1, 1, 0, 4);
        cyc();
        expect_all("t3_n2a", 0, 0, 1, 1, 2);
        cyc();
        expect_all("t3_n2b", 1, 0, 1, 1, 2);
        cyc();
        expect_all("t3_n2c", 0, 1, 1, 1, 2);
        cyc();
        expect_all("t3_n2d", 1, 1, 1, 1, 2);
        bus_if.start = 1'b0;
        cyc();
        expect_all("t3_dr1", 0, 0, 1, 0, 2);
        cyc();
        expect_all("t3_dr2", 1, 0, 1, 0, 2);
        cyc();
        expect_all("t3_idle", 0, 1, 0, 1, 2);

        // N=5, stop pulsed at counter=1 with start still high: 3 drain cycles, start ignored
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_div   = 8'd5;
        bus_if.start     = 1'b1;
        cyc();
        bus_if.cfg_valid = 1'b0;
        expect_all("t4_c0", 0, 1, 1, 1, 5);
        cyc();
        expect_all("t4_c1", 0, 1, 1, 1, 5);
        bus_if.stop = 1'b1;
        cyc();
        bus_if.stop = 1'b0;
        expect_all("t4_dr2", 0, 1, 1, 0, 5);
        cyc();
        expect_all("t4_dr3", 0, 1, 1, 0, 5);
        cyc();
        expect_all("t4_dr4", 1, 1, 1, 0, 5);
        bus_if.start = 1'b0;
        cyc();
        expect_all("t4_idle", 0, 0, 0, 1, 5);
        cyc();
        expect_all("t4_hold", 0, 0, 0, 1, 5);

        // N=6, pending divisor queued, reset asserted at counter=3 of the second period
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_div   = 8'd6;
        bus_if.start     = 1'b1;
        cyc();
        bus_if.cfg_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expect_all($sformatf("t5_run%0d", i), (i == 5), (i > 5), 1, (i < 8), 6);
            bus_if.cfg_valid = (i == 7);
            bus_if.cfg_div   = 8'd9;
            if (i < 9) cyc();
        end
        bus_if.cfg_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        expect_all("t5_rst", 0, 0, 0, 1, 1);
        bus_if.start = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        expect_all("t5_post", 0, 0, 0, 1, 1);

        // start and stop together in IDLE: one RUN cycle, then DRAIN
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_div   = 8'd3;
        bus_if.start     = 1'b1;
        bus_if.stop      = 1'b1;
        cyc();
        bus_if.cfg_valid = 1'b0;
        bus_if.stop      = 1'b0;
        expect_all("t6_run", 0, 0, 1, 1, 3);
        cyc();
        expect_all("t6_dr1", 0, 0, 1, 0, 3);
        cyc();
        expect_all("t6_dr2", 1, 0, 1, 0, 3);
        bus_if.start = 1'b0;
        cyc();
        expect_all("t6_idle", 0, 1, 0, 1, 3);

`ifdef DIVIDER_SEQUENCER_BURST_EN
        // burst_len=3, N=2, start held: three ticks, one burst_done, stays IDLE
        begin
            int ticks = 0;
            int dones = 0;
            bus_if.cfg_valid = 1'b1;
            bus_if.cfg_div   = 8'd2;
            bus_if.burst_len = 8'd3;
            bus_if.start     = 1'b1;
            cyc();
            bus_if.cfg_valid = 1'b0;
            for (int i = 0; i < 12; i++) begin
                ticks += int'(bus_if.tick);
                dones += int'(bus_if.burst_done);
                cyc();
            end
            check("burst_ticks", ticks, 3);
            check("burst_dones", dones, 1);
            check("burst_busy", bus_if.busy, 0);
            bus_if.start = 1'b0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
